// File: rtl/bp_pkg.sv
// Shared constants and types for the dynamic branch predictor (BTB + saturating counters).
package bp_pkg;

  localparam int DEF_ENTRIES   = 16;
  localparam int DEF_TAG_BITS  = 10;
  localparam int DEF_CNT_BITS  = 2;
  localparam int DEF_PERF_BITS = 16;

  // Weakly not-taken: MSB clear, all lower bits set (e.g. 2'b01).
  function automatic int cnt_reset_val(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Weakly taken: only the MSB set (e.g. 2'b10). Used when a taken branch allocates a line.
  function automatic int cnt_alloc_val(input int width);
    return 1 << (width - 1);
  endfunction

  // One BTB line at the default geometry.
  typedef struct packed {
    logic                    valid;
    logic [DEF_TAG_BITS-1:0] tag;
    logic [31:0]             target;
    logic [DEF_CNT_BITS-1:0] cnt;
  } bp_line_t;

  // Result of a combinational lookup.
  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } bp_pred_t;

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Lookup/update/perf bundle between the pipeline (master) and the predictor (slave).
interface branch_predictor_btb_if #(
  parameter int PERF_BITS = 16
);
  logic                 clear_i;
  logic [31:0]          lookup_pc_i;
  logic                 pred_hit_o;
  logic                 pred_taken_o;
  logic [31:0]          pred_target_o;
  logic                 upd_valid_i;
  logic [31:0]          upd_pc_i;
  logic                 upd_taken_i;
  logic [31:0]          upd_target_i;
  logic                 upd_mispred_i;
  logic [PERF_BITS-1:0] perf_branches_o;
  logic [PERF_BITS-1:0] perf_mispred_o;

  modport master (
    output clear_i, lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_mispred_i,
    input  pred_hit_o, pred_taken_o, pred_target_o, perf_branches_o, perf_mispred_o
  );

  modport slave (
    input  clear_i, lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_mispred_i,
    output pred_hit_o, pred_taken_o, pred_target_o, perf_branches_o, perf_mispred_o
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up/down counter with a synchronous load; used for BTB direction and perf counts.
module sat_counter #(
  parameter int               WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] value_d, value_q;

  // Load wins; inc and dec together cancel; otherwise step and clamp at the ends.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (inc_i && !dec_i) begin
      if (value_q != '1) value_d = value_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (value_q != '0) value_d = value_q - 1'b1;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_q <= RST_VAL;
    else       value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-line saturating direction counters and two perf counters.
// Lookup is combinational on pre-edge state; one update per cycle from branch resolution.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int ENTRIES   = DEF_ENTRIES,
  parameter int TAG_BITS  = DEF_TAG_BITS,
  parameter int CNT_BITS  = DEF_CNT_BITS,
  parameter int PERF_BITS = DEF_PERF_BITS
) (
  input logic                    clk,
  input logic                    reset,
  branch_predictor_btb_if.slave  bus
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam logic [CNT_BITS-1:0] CNT_RST   = CNT_BITS'(cnt_reset_val(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CNT_ALLOC = CNT_BITS'(cnt_alloc_val(CNT_BITS));

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [31:0]         target;
  } line_t;

  line_t               line_arr [ENTRIES];
  logic [CNT_BITS-1:0] cnt_arr  [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx, upd_idx;
  logic [TAG_BITS-1:0] lk_tag, upd_tag;
  line_t               lk_line, upd_line;
  logic [CNT_BITS-1:0] lk_cnt;
  logic                upd_hit, upd_en;
  bp_pred_t            pred;

  // Only the index and tag fields of the update PC matter; the rest is deliberately ignored.
  wire unused_upd_pc = ^bus.upd_pc_i;

  assign lk_idx  = bus.lookup_pc_i[IDX_BITS+1:2];
  assign lk_tag  = bus.lookup_pc_i[IDX_BITS+2 +: TAG_BITS];
  assign upd_idx = bus.upd_pc_i[IDX_BITS+1:2];
  assign upd_tag = bus.upd_pc_i[IDX_BITS+2 +: TAG_BITS];

  assign lk_line  = line_arr[lk_idx];
  assign lk_cnt   = cnt_arr[lk_idx];
  assign upd_line = line_arr[upd_idx];

  // Clear overrides any update in the same cycle.
  assign upd_en  = bus.upd_valid_i && !bus.clear_i;
  assign upd_hit = upd_line.valid && (upd_line.tag == upd_tag);

  // Combinational prediction from the current (pre-edge) table contents.
  always_comb begin
    pred.hit    = lk_line.valid && (lk_line.tag == lk_tag);
    pred.taken  = pred.hit && lk_cnt[CNT_BITS-1];
    pred.target = pred.taken ? lk_line.target : (bus.lookup_pc_i + 32'd4);
  end

  assign bus.pred_hit_o    = pred.hit;
  assign bus.pred_taken_o  = pred.taken;
  assign bus.pred_target_o = pred.target;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_line
    line_t               line_d, line_q;
    logic                sel;
    logic                cnt_inc, cnt_dec, cnt_load;
    logic [CNT_BITS-1:0] cnt_load_val;
    logic [CNT_BITS-1:0] cnt_val;

    assign sel = upd_en && (upd_idx == IDX_BITS'(gi));

    // Counter control: step on a hit, seed weakly-taken on allocation, restore on clear.
    always_comb begin
      cnt_inc      = sel && upd_hit && bus.upd_taken_i;
      cnt_dec      = sel && upd_hit && !bus.upd_taken_i;
      cnt_load     = bus.clear_i || (sel && !upd_hit && bus.upd_taken_i);
      cnt_load_val = bus.clear_i ? CNT_RST : CNT_ALLOC;
    end

    // Line contents: invalidate on clear, allocate on taken miss, retarget on taken hit.
    always_comb begin
      line_d = line_q;
      if (bus.clear_i) begin
        line_d.valid = 1'b0;
      end else if (sel && bus.upd_taken_i) begin
        line_d.valid  = 1'b1;
        line_d.tag    = upd_tag;
        line_d.target = bus.upd_target_i;
      end
    end

    // Line storage register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) line_q <= '0;
      else       line_q <= line_d;
    end

    sat_counter #(
      .WIDTH   (CNT_BITS),
      .RST_VAL (CNT_RST)
    ) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .inc_i      (cnt_inc),
      .dec_i      (cnt_dec),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .value_o    (cnt_val)
    );

    assign line_arr[gi] = line_q;
    assign cnt_arr[gi]  = cnt_val;
  end

  // Perf counters count every resolved branch, even on a clear cycle.
  sat_counter #(
    .WIDTH   (PERF_BITS),
    .RST_VAL ('0)
  ) u_perf_branches (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (bus.upd_valid_i),
    .dec_i      (1'b0),
    .load_i     (1'b0),
    .load_val_i ('0),
    .value_o    (bus.perf_branches_o)
  );

  sat_counter #(
    .WIDTH   (PERF_BITS),
    .RST_VAL ('0)
  ) u_perf_mispred (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (bus.upd_valid_i && bus.upd_mispred_i),
    .dec_i      (1'b0),
    .load_i     (1'b0),
    .load_val_i ('0),
    .value_o    (bus.perf_mispred_o)
  );

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb (ENTRIES=16, TAG_BITS=10, CNT_BITS=2, PERF_BITS=4).
module tb_branch_predictor_btb;

  localparam int PERF_BITS = 4;
  localparam int PERF_MAX  = 15;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   br_m;
  int   mp_m;

  branch_predictor_btb_if #(.PERF_BITS(PERF_BITS)) bus ();

  branch_predictor_btb #(
    .ENTRIES   (16),
    .TAG_BITS  (10),
    .CNT_BITS  (2),
    .PERF_BITS (PERF_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_hit, input logic exp_taken, input logic [31:0] exp_tgt);
    @(negedge clk);
    bus.lookup_pc_i = pc;
    #1;
    $display("lookup %s pc=%08h hit=%0b taken=%0b target=%08h", tag, pc,
             bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o);
    chk({tag, "_hit"},    {31'd0, bus.pred_hit_o},   {31'd0, exp_hit});
    chk({tag, "_taken"},  {31'd0, bus.pred_taken_o}, {31'd0, exp_taken});
    chk({tag, "_target"}, bus.pred_target_o,         exp_tgt);
  endtask

  task automatic model_perf(input logic mp);
    if (br_m < PERF_MAX) br_m++;
    if (mp && mp_m < PERF_MAX) mp_m++;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt, input logic mp);
    @(negedge clk);
    bus.upd_valid_i   = 1'b1;
    bus.upd_pc_i      = pc;
    bus.upd_taken_i   = taken;
    bus.upd_target_i  = tgt;
    bus.upd_mispred_i = mp;
    @(posedge clk);
    #1;
    // Junk on the update fields while idle must be ignored.
    bus.upd_valid_i   = 1'b0;
    bus.upd_pc_i      = 32'h0000_0100;
    bus.upd_taken_i   = 1'b1;
    bus.upd_target_i  = 32'hDEAD_BEEF;
    bus.upd_mispred_i = 1'b1;
    model_perf(mp);
    $display("update pc=%08h taken=%0b target=%08h mispred=%0b", pc, taken, tgt, mp);
  endtask

  task automatic chk_perf(input string tag);
    #1;
    $display("perf %s branches=%0d mispred=%0d", tag, bus.perf_branches_o, bus.perf_mispred_o);
    chk({tag, "_branches"}, 32'(bus.perf_branches_o), 32'(br_m));
    chk({tag, "_mispred"},  32'(bus.perf_mispred_o),  32'(mp_m));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    br_m  = 0;
    mp_m  = 0;
    reset = 1'b1;
    bus.clear_i       = 1'b0;
    bus.lookup_pc_i   = 32'h0;
    bus.upd_valid_i   = 1'b0;
    bus.upd_pc_i      = 32'h0;
    bus.upd_taken_i   = 1'b0;
    bus.upd_target_i  = 32'h0;
    bus.upd_mispred_i = 1'b0;
    #12 reset = 1'b0;

    // 1. Reset state
    lookup("rst", 32'h100, 1'b0, 1'b0, 32'h104);
    chk_perf("rst");

    // 2. Allocate on taken miss -> weakly taken
    upd(32'h100, 1'b1, 32'h200, 1'b1);
    lookup("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

    // 3. Decrement to 0 and hold, then climb and saturate at 3
    upd(32'h100, 1'b0, 32'h999, 1'b1);              // 2->1
    lookup("dec1", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h999, 1'b0);              // 1->0
    upd(32'h100, 1'b0, 32'h999, 1'b0);              // 0->0
    lookup("dec_sat", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h200, 1'b1);              // 0->1
    lookup("inc1", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h200, 1'b1);              // 1->2
    lookup("inc2", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h200, 1'b0);              // 2->3
    upd(32'h100, 1'b1, 32'h200, 1'b0);              // 3->3
    upd(32'h100, 1'b0, 32'h999, 1'b1);              // 3->2, target kept
    lookup("inc_sat", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h999, 1'b1);              // 2->1
    lookup("after_sat", 32'h100, 1'b1, 1'b0, 32'h104);
    chk_perf("mid");

    // 4. Alias at index 0 evicts the previous occupant; pc[1:0] ignored
    upd(32'h140, 1'b1, 32'h300, 1'b1);
    lookup("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    lookup("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);
    lookup("alias_lsb", 32'h143, 1'b1, 1'b1, 32'h300);

    // Not-taken miss does not allocate
    upd(32'h208, 1'b0, 32'h700, 1'b0);
    lookup("nt_miss", 32'h208, 1'b0, 1'b0, 32'h20C);

    // 5. Same-cycle update and lookup: old contents now, new ones next cycle
    @(negedge clk);
    bus.lookup_pc_i   = 32'h180;
    bus.upd_valid_i   = 1'b1;
    bus.upd_pc_i      = 32'h180;
    bus.upd_taken_i   = 1'b1;
    bus.upd_target_i  = 32'h400;
    bus.upd_mispred_i = 1'b1;
    #1;
    $display("same-cycle lookup pc=00000180 hit=%0b target=%08h", bus.pred_hit_o, bus.pred_target_o);
    chk("same_old_hit",    {31'd0, bus.pred_hit_o}, 32'd0);
    chk("same_old_target", bus.pred_target_o,       32'h184);
    @(posedge clk);
    #1;
    bus.upd_valid_i = 1'b0;
    model_perf(1'b1);
    lookup("same_new", 32'h180, 1'b1, 1'b1, 32'h400);

    // clear_i overrides a simultaneous allocating update
    @(negedge clk);
    bus.clear_i       = 1'b1;
    bus.upd_valid_i   = 1'b1;
    bus.upd_pc_i      = 32'h104;
    bus.upd_taken_i   = 1'b1;
    bus.upd_target_i  = 32'h500;
    bus.upd_mispred_i = 1'b0;
    @(posedge clk);
    #1;
    bus.clear_i     = 1'b0;
    bus.upd_valid_i = 1'b0;
    model_perf(1'b0);
    $display("clear with update pc=00000104");
    lookup("clr_a", 32'h180, 1'b0, 1'b0, 32'h184);
    lookup("clr_b", 32'h104, 1'b0, 1'b0, 32'h108);
    chk_perf("clr");

    // PC+4 wraps at the top of the address space
    lookup("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // 6. Perf counters saturate at all-ones
    for (int i = 0; i < 20; i++) upd(32'h808, 1'b0, 32'h0, 1'b1);
    chk_perf("perf_sat");
    chk("perf_sat_abs", 32'(bus.perf_branches_o), 32'd15);

    // Asynchronous reset in the middle of an update cycle
    upd(32'h100, 1'b1, 32'h600, 1'b0);
    lookup("pre_rst", 32'h100, 1'b1, 1'b1, 32'h600);
    @(negedge clk);
    bus.upd_valid_i   = 1'b1;
    bus.upd_pc_i      = 32'h100;
    bus.upd_taken_i   = 1'b1;
    bus.upd_target_i  = 32'h700;
    bus.upd_mispred_i = 1'b1;
    #2 reset = 1'b1;
    #1;
    br_m = 0;
    mp_m = 0;
    $display("async reset mid-update hit=%0b target=%08h", bus.pred_hit_o, bus.pred_target_o);
    chk("arst_hit",    {31'd0, bus.pred_hit_o},   32'd0);
    chk("arst_taken",  {31'd0, bus.pred_taken_o}, 32'd0);
    chk("arst_target", bus.pred_target_o,         32'h104);
    chk_perf("arst");
    bus.upd_valid_i = 1'b0;
    #1 reset = 1'b0;
    lookup("post_rst", 32'h100, 1'b0, 1'b0, 32'h104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
